// File: rtl/sel_decode_unit.sv
// rtl/sel_decode_unit.sv - IR latch, gra/grb/grc field select and one-hot register-file enable decode.
// Optional SEL_DECODE_STATS_EN adds decode_cnt, a saturating count of legal strobed requests.
module sel_decode_unit #(
  parameter int NREG    = 16,
  parameter int FIELD_W = 4
) (
  input  logic               clk,
  input  logic               clr,
  input  logic               ir_ld,
  input  logic [31:0]        ir_in,
  input  logic               gra,
  input  logic               grb,
  input  logic               grc,
  input  logic               rin,
  input  logic               rout,
  input  logic               baout,
  input  logic               err_clr,
  output logic [NREG-1:0]    r_in,
  output logic [NREG-1:0]    r_out,
  output logic               zero_drive,
  output logic [31:0]        c_sext,
  output logic [4:0]         opcode,
  output logic [FIELD_W-1:0] sel_idx,
  output logic               sel_err
`ifdef SEL_DECODE_STATS_EN
  ,
  output logic [15:0]        decode_cnt
`endif
);

  logic [31:0]        ir_q, ir_d;
  logic [NREG-1:0]    r_in_q, r_in_d;
  logic [NREG-1:0]    r_out_q, r_out_d;
  logic               zero_q, zero_d;
  logic [FIELD_W-1:0] idx_q, idx_d;
  logic               err_q, err_d;

  logic [1:0]         n_gr, n_st;
  logic               illegal, active;
  logic [FIELD_W-1:0] field;
  logic [NREG-1:0]    onehot;

  assign n_gr    = 2'(gra) + 2'(grb) + 2'(grc);
  assign n_st    = 2'(rin) + 2'(rout) + 2'(baout);
  assign illegal = (n_gr > 2'd1) || (n_st > 2'd1);
  assign active  = (n_gr == 2'd1) && !illegal;
  assign onehot  = {{(NREG-1){1'b0}}, 1'b1} << field;

  // Decode always looks at the latched IR, so a same-cycle ir_ld only takes effect next cycle.
  always_comb begin
    field = ir_q[18 -: FIELD_W];
    if (gra)      field = ir_q[26 -: FIELD_W];
    else if (grb) field = ir_q[22 -: FIELD_W];
  end

  always_comb begin
    ir_d    = ir_ld ? ir_in : ir_q;
    r_in_d  = '0;
    r_out_d = '0;
    zero_d  = 1'b0;
    idx_d   = idx_q;
    err_d   = err_q;
    if (illegal) begin
      err_d = 1'b1;
    end else begin
      if (err_clr) err_d = 1'b0;
      if (active) begin
        idx_d = field;
        if (rin) r_in_d = onehot;
        // R0 used as a base address reads as zero instead of driving the bus.
        if (rout || (baout && field != '0)) r_out_d = onehot;
        if (baout && field == '0) zero_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (clr) begin
      ir_q    <= '0;
      r_in_q  <= '0;
      r_out_q <= '0;
      zero_q  <= 1'b0;
      idx_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      ir_q    <= ir_d;
      r_in_q  <= r_in_d;
      r_out_q <= r_out_d;
      zero_q  <= zero_d;
      idx_q   <= idx_d;
      err_q   <= err_d;
    end
  end

`ifdef SEL_DECODE_STATS_EN
  logic [15:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (err_clr)                                    cnt_d = '0;
    else if (active && (n_st != 2'd0) && cnt_q != 16'hFFFF) cnt_d = cnt_q + 16'd1;
  end

  always_ff @(posedge clk) begin
    if (clr) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

  assign decode_cnt = cnt_q;
`endif

  assign r_in       = r_in_q;
  assign r_out      = r_out_q;
  assign zero_drive = zero_q;
  assign sel_idx    = idx_q;
  assign sel_err    = err_q;
  assign c_sext     = {{13{ir_q[18]}}, ir_q[18:0]};
  assign opcode     = ir_q[31:27];

endmodule

// File: doc/sel_decode_unit.md
Name: sel_decode_unit

Overview:
- Select-and-decode stage for the datapath; the write-side counterpart of the 32-to-5 bus-source encoder.
- Latches the instruction register and picks the Ra, Rb or Rc field under gra/grb/grc.
- Decodes the chosen field to registered one-hot register-file enables (r_in, r_out) and produces the sign-extended C constant.
- Flags illegal strobe combinations with a sticky error flag.

Parameters:
- NREG, 16, number of general registers; width of one-hot enables, must be 2**FIELD_W.
- FIELD_W, 4, width of each register field in the IR.

Ports:
- clk  input  1  system clock; all state on rising edge.
- clr  input  1  reset, synchronous, active-high.
- ir_ld  input  1  capture ir_in into the internal IR.
- ir_in  input  32  instruction word from the bus.
- gra  input  1  select Ra field, IR[26:23].
- grb  input  1  select Rb field, IR[22:19].
- grc  input  1  select Rc field, IR[18:15].
- rin  input  1  write strobe: selected register loads from bus.
- rout  input  1  read strobe: selected register drives bus.
- baout  input  1  base-address read strobe; R0 reads as zero.
- err_clr  input  1  clears sel_err.
- r_in  output  NREG  one-hot register load enables.
- r_out  output  NREG  one-hot register bus-drive enables.
- zero_drive  output  1  bus must carry 32'h0 this cycle (baout with field 0).
- c_sext  output  32  IR[18:0] sign-extended from bit 18.
- opcode  output  5  IR[31:27].
- sel_idx  output  FIELD_W  last successfully decoded field value.
- sel_err  output  1  sticky illegal-request flag.

Behaviour:
- Reset (clr high at edge): IR=0; r_in, r_out=0; zero_drive=0; sel_idx=0; sel_err=0. clr has priority over all other inputs.
- IR: loaded on ir_ld. Decode in the same cycle uses the old IR value; the new value is used from the next cycle. c_sext and opcode are combinational from the latched IR.
- Field select: f = Ra, Rb or Rc per the single asserted gr* signal.
- Latency: strobes sampled at edge N; r_in/r_out/zero_drive valid for exactly the cycle after edge N. They are re-evaluated every edge, so they are single-cycle pulses unless strobes stay asserted.
- Legal request: exactly one of gra/grb/grc, and at most one of rin/rout/baout. Then:
  - rin -> r_in = 1<<f.
  - rout -> r_out = 1<<f.
  - baout with f!=0 -> r_out = 1<<f, zero_drive=0.
  - baout with f==0 -> r_out=0, zero_drive=1.
  - sel_idx <= f.
- Any of rin/rout/baout with no gr* asserted: outputs 0, no error (idle).
- gr* asserted with no strobe: outputs 0, sel_idx <= f, no error.
- Illegal request (two or more gr*, or two or more of rin/rout/baout): r_in=r_out=0, zero_drive=0, sel_idx unchanged, sel_err <= 1.
- sel_err: sticky. Cleared by err_clr or clr. If err_clr and a new illegal request occur in the same cycle, set wins.
- Invariant: r_in and r_out each have at most one bit set; r_out and zero_drive are never both active.
- No state machine beyond the registered outputs and IR/err flops. Fully pipelined, one request per cycle, no backpressure.

Optional Feature:
- Macro: SEL_DECODE_STATS_EN.
- Defined: adds output decode_cnt [15:0], reset to 0. It increments by 1 on each legal request carrying a strobe and saturates at 16'hFFFF; err_clr also clears it.
- Undefined: port absent, no counter logic; all other behaviour identical.

Test Plan:
- Reset: clr=1 with all strobes high -> next cycle r_in=r_out=0, sel_err=0, IR=0, c_sext=0.
- Write decode: ir_ld with ir_in=32'h1A980000 (Ra=5, Rb=3); next cycle gra+rin -> following cycle r_in=16'h0020, r_out=0, sel_idx=5; strobes drop -> r_in=0 next cycle.
- Read and base-address: IR Rb=0, Rc=15; grc+rout -> r_out=16'h8000; grb+baout -> r_out=0, zero_drive=1.
- Sign extension: IR[18:0]=19'h40001 -> c_sext=32'hFFFC0001; IR[18:0]=19'h00007 -> 32'h00000007.
- Illegal and sticky: gra+grb+rin -> r_in=0, sel_err=1; sel_err stays 1 through a later legal request; err_clr -> 0; err_clr plus a simultaneous illegal request -> sel_err stays 1.
- Load/decode overlap: ir_ld (new Ra=9) with gra+rout in the same cycle, old Ra=2 -> r_out=16'h0004. Repeat the request next cycle -> r_out=16'h0200.
